fetch_decode_buffer: RTL

//  Elastic IF/ID boundary between fetch_stage and the decode stage. Queues up to DEPTH

---
 rtl/fetch_decode_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID queue: buffers fetched {instr, pc, pc+4, xcpt} bundles between fetch and decode.
// Optional performance counters are built when FETCH_DECODE_BUFFER_PERF_EN is defined.
module fetch_decode_buffer #(
  parameter int                  DEPTH     = 2,
  parameter int                  ILEN      = 32,
  parameter int                  XLEN      = 32,
  parameter int                  XCPT_W    = 3,
  parameter logic [ILEN-1:0]     NOP_INSTR = 32'h0000_0013,
  parameter logic [XCPT_W-1:0]   NO_XCPT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [ILEN-1:0]   instr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   pc_plus4_in,
  input  logic [XCPT_W-1:0] xcpt_in,
  input  logic              flush_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [ILEN-1:0]   instr_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pc_plus4_out,
  output logic [XCPT_W-1:0] xcpt_out
`ifdef FETCH_DECODE_BUFFER_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_out,
  output logic [31:0]       perf_bubble_cnt_out,
  output logic [31:0]       perf_flush_cnt_out
`endif
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [ILEN-1:0]   r_instr_mem [DEPTH];
  logic [XLEN-1:0]   r_pc_mem    [DEPTH];
  logic [XLEN-1:0]   r_pc4_mem   [DEPTH];
  logic [XCPT_W-1:0] r_xcpt_mem  [DEPTH];

  logic w_push;
  logic w_pop;

  // Handshake flags depend only on the registered count, so decode never reaches fetch combinationally.
  assign ready_out = (r_count != FULL_CNT);
  assign valid_out = (r_count != '0);
  assign w_push    = valid_in & ready_out;
  assign w_pop     = valid_out & ready_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; r_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (reset && !flush_in && w_push) begin
      r_instr_mem[r_wr_ptr] <= instr_in;
      r_pc_mem[r_wr_ptr]    <= pc_in;
      r_pc4_mem[r_wr_ptr]   <= pc_plus4_in;
      r_xcpt_mem[r_wr_ptr]  <= xcpt_in;
    end
  end

  // NOTE: every output gets a default before the conditional read, so no latch is inferred.
  always_comb begin
    instr_out    = NOP_INSTR;
    pc_out       = '0;
    pc_plus4_out = '0;
    xcpt_out     = NO_XCPT;
    if (valid_out) begin
      instr_out    = r_instr_mem[r_rd_ptr];
      pc_out       = r_pc_mem[r_rd_ptr];
      pc_plus4_out = r_pc4_mem[r_rd_ptr];
      xcpt_out     = r_xcpt_mem[r_rd_ptr];
    end
  end

`ifdef FETCH_DECODE_BUFFER_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_bubble_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Counters saturate rather than wrap so long runs never report a misleadingly small value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_stall_cnt  <= '0;
      r_perf_bubble_cnt <= '0;
      r_perf_flush_cnt  <= '0;
    end else begin
      if (valid_in && !ready_out && (r_perf_stall_cnt != 32'hFFFF_FFFF))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (ready_in && !valid_out && (r_perf_bubble_cnt != 32'hFFFF_FFFF))
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      if (flush_in && (r_perf_flush_cnt != 32'hFFFF_FFFF))
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_out  = r_perf_stall_cnt;
  assign perf_bubble_cnt_out = r_perf_bubble_cnt;
  assign perf_flush_cnt_out  = r_perf_flush_cnt;
`endif

endmodule
